// File: rtl/ps2_kbd_ctrl.sv
// Drains the PS/2 receiver FIFO and folds E0/F0 prefixes into single key events.
// Tracks the held key for typematic-repeat flagging and counts distinct presses.
module ps2_kbd_ctrl #(
  parameter int CNT_W        = 8,
  parameter bit DROP_SPECIAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       kb_data,
  input  logic             kb_ready,
  input  logic             kb_overflow,
  output logic             kb_nextdata_n,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  output logic             ev_repeat,
  output logic             held_valid,
  output logic [8:0]       held_code,
  output logic [CNT_W-1:0] press_cnt,
  output logic             ovf_seen,
  input  logic             ovf_clr
);

  typedef enum logic [1:0] {IDLE, ACK, SETTLE, EMIT} state_t;

  state_t     state;
  logic [7:0] byte_r;
  logic       ext_f, brk_f;
  logic       special;
  logic       is_rep;

  // Controller chatter (BAT, ACK, resend, errors) that never maps to a key.
  always_comb begin
    special = 1'b0;
    if (DROP_SPECIAL)
      special = byte_r inside {8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFE, 8'hFF};
  end

  assign is_rep = !brk_f && held_valid && (held_code == {ext_f, byte_r});

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      byte_r        <= 8'h00;
      ext_f         <= 1'b0;
      brk_f         <= 1'b0;
      kb_nextdata_n <= 1'b1;
      ev_valid      <= 1'b0;
      ev_code       <= 8'h00;
      ev_ext        <= 1'b0;
      ev_break      <= 1'b0;
      ev_repeat     <= 1'b0;
      held_valid    <= 1'b0;
      held_code     <= 9'h000;
      press_cnt     <= '0;
      ovf_seen      <= 1'b0;
    end else begin
      if (kb_overflow)  ovf_seen <= 1'b1;
      else if (ovf_clr) ovf_seen <= 1'b0;

      case (state)
        IDLE: if (kb_ready) begin
          byte_r        <= kb_data;
          kb_nextdata_n <= 1'b0;
          state         <= ACK;
        end
        ACK: begin
          kb_nextdata_n <= 1'b1;
          if (byte_r == 8'hE0) begin
            ext_f <= 1'b1;
            state <= SETTLE;
          end else if (byte_r == 8'hF0) begin
            brk_f <= 1'b1;
            state <= SETTLE;
          end else if (special) begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
            state <= SETTLE;
          end else begin
            ev_code   <= byte_r;
            ev_ext    <= ext_f;
            ev_break  <= brk_f;
            ev_repeat <= is_rep;
            ev_valid  <= 1'b1;
            state     <= EMIT;
          end
        end
        SETTLE: state <= IDLE;
        // Doubles as the settle cycle; FIFO stays untouched until the consumer accepts.
        EMIT: if (ev_ready) begin
          ev_valid <= 1'b0;
          ext_f    <= 1'b0;
          brk_f    <= 1'b0;
          state    <= IDLE;
          if (!ev_break) begin
            if (!ev_repeat) begin
              held_valid <= 1'b1;
              held_code  <= {ev_ext, ev_code};
              press_cnt  <= press_cnt + CNT_W'(1);
            end
          end else if (held_code == {ev_ext, ev_code}) begin
            held_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
Sequencer that drains the PS/2 receiver's scancode FIFO and turns raw Set-2 byte streams into key events. It drives the receiver's active-low pop strobe and folds E0 (extended) and F0 (break) prefixes into single events. It tracks the currently held key to flag typematic repeats, and counts distinct key presses. It sits between the PS/2 receiver and the keyboard consumer (display/ASCII logic), using a valid/ready event handshake.

Parameters:
CNT_W, 8, width of press counter; wraps modulo 2^CNT_W
DROP_SPECIAL, 1, 1 = discard controller bytes 0x00, 0xAA, 0xE1, 0xFA, 0xFE, 0xFF without event; 0 = emit them as plain make events

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  synchronous reset, active-high
kb_data  input  8  receiver FIFO head byte, valid while kb_ready=1
kb_ready  input  1  receiver FIFO non-empty
kb_overflow  input  1  receiver FIFO overflow flag
kb_nextdata_n  output  1  active-low pop strobe to receiver, exactly one cycle per consumed byte
ev_valid  output  1  key event available
ev_ready  input  1  consumer accepts event
ev_code  output  8  scancode, prefix bytes stripped
ev_ext  output  1  event carried E0 prefix
ev_break  output  1  1 = key release, 0 = key press
ev_repeat  output  1  make event equal to currently held key (typematic)
held_valid  output  1  a key is currently held
held_code  output  9  {ext, code} of held key
press_cnt  output  CNT_W  count of non-repeat make events
ovf_seen  output  1  sticky copy of kb_overflow
ovf_clr  input  1  clears ovf_seen

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; kb_nextdata_n=1; ev_valid=0; ev_code=0; ev_ext/ev_break/ev_repeat=0; held_valid=0; held_code=0; press_cnt=0; ovf_seen=0; prefix flags ext_f/brk_f=0. Reset mid-event drops any in-flight byte, flags and pending event; the receiver FIFO is not popped.
- All outputs registered.
- States: IDLE, ACK, SETTLE, EMIT.
- IDLE: if kb_ready=1, latch kb_data into byte_r, drive kb_nextdata_n<=0, go to ACK. Otherwise stay.
- ACK (kb_nextdata_n=0 this cycle only; kb_nextdata_n<=1): decode byte_r:
  - 0xE0: ext_f<=1, go to SETTLE.
  - 0xF0: brk_f<=1, go to SETTLE.
  - special byte with DROP_SPECIAL=1: clear ext_f/brk_f, go to SETTLE.
  - otherwise load ev_code=byte_r, ev_ext=ext_f, ev_break=brk_f. Load ev_repeat=(!brk_f && held_valid && held_code=={ext_f,byte_r}). Set ev_valid<=1, go to EMIT.
- SETTLE: one dead cycle so kb_ready/kb_data reflect the pop, then IDLE.
- EMIT: hold ev_valid and all ev_* stable until ev_ready=1 at a clk edge. On that edge: ev_valid<=0, clear ext_f/brk_f, go to IDLE. EMIT also serves as the settle cycle. ev_ready is ignored when ev_valid=0.
- Held/count updates occur on the handshake edge:
  - make, non-repeat: held_valid<=1, held_code<={ev_ext,ev_code}, press_cnt<=press_cnt+1 (wraps).
  - make, repeat: no change.
  - break matching held_code: held_valid<=0.
  - break of any other key: no change.
- Latency: kb_ready seen in IDLE at cycle t -> kb_nextdata_n=0 at t+1 -> ev_valid=1 at t+2. Prefix bytes cost 3 cycles each.
- Throughput: with ev_ready tied high, one byte every 3 cycles. The FIFO is never popped while ev_valid=1, giving backpressure to the receiver.
- Prefix order E0 F0 xx yields ext=1, break=1. A lone F0 or E0 followed by a special byte is discarded and the flags cleared.
- ovf_seen is set when kb_overflow=1. If ovf_clr and kb_overflow are both 1 in the same cycle, set wins. Overflow does not alter sequencing.

Test Plan:
- FIFO holds 0x1C, ev_ready=1 -> kb_nextdata_n low exactly 1 cycle; ev_valid at t+2 with code=0x1C ext=0 break=0 repeat=0; held_code=0x01C; press_cnt=1.
- Bytes F0,1C after the above -> single event code=0x1C break=1; held_valid=0; press_cnt stays 1; exactly 2 pops.
- Bytes E0,75 then E0,F0,75 -> make ext=1 code=0x75, then break ext=1; held_code 0x175 then held_valid=0.
- Bytes 1C,1C,1C (typematic) -> first repeat=0, next two repeat=1; press_cnt increments once.
- ev_ready=0 for 10 cycles with 3 bytes queued -> ev_valid and ev_* stable, no further pops; release -> remaining bytes are consumed in order.
- Byte 0xAA (DROP_SPECIAL=1) -> popped, no event. kb_overflow pulse -> ovf_seen=1 until ovf_clr. rst asserted in ACK -> all outputs at reset values next cycle and kb_nextdata_n=1.
